// File: rtl/ssp_tx_framer.sv
// SSP transmit framer: byte FIFO feeding an MSB-first serializer on a free-running divided ssp_clk.
// Optional build macro SSP_TX_IDLE_FILL_EN sends 0x00 fill frames whenever the FIFO runs dry.
module ssp_tx_framer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 8
) (
    input  logic                          ck_1356meg,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          ssp_clk,
    output logic                          ssp_frame,
    output logic                          ssp_din
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             rise_tick;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       rd_data;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       shreg_q;
    logic [7:0]       shreg_d;
    logic [2:0]       bit_cnt_q;
    logic [2:0]       bit_cnt_d;
    logic             din_d;
    logic             frame_d;
    logic             start_byte;

    // ------------------------------------------------------------------ divider
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            div_cnt <= '0;
            ssp_clk <= 1'b0;
        end else if (div_cnt == DIV_RISE) begin
            div_cnt <= '0;
            ssp_clk <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            if (div_cnt == DIV_FALL) begin
                ssp_clk <= 1'b0;
            end
        end
    end

    assign rise_tick = (div_cnt == DIV_RISE);

    // ------------------------------------------------------------------ FIFO
    assign full     = (fifo_level == LVL_FULL);
    assign empty    = (fifo_level == '0);
    assign tx_ready = ~full & ~rst;
    assign push     = tx_valid & tx_ready;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge ck_1356meg) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Full is judged from the registered level, so a same-edge pop never rescues a push.
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (tx_valid && !tx_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise_tick) begin
            case (state_q)
                IDLE: begin
`ifdef SSP_TX_IDLE_FILL_EN
                    state_d = SHIFT;
`else
                    if (!empty) begin
                        state_d = SHIFT;
                    end
`endif
                end
                SHIFT: begin
`ifndef SSP_TX_IDLE_FILL_EN
                    if (bit_cnt_q == '0 && empty) begin
                        state_d = IDLE;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pop        = 1'b0;
        start_byte = 1'b0;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        din_d      = ssp_din;
        frame_d    = ssp_frame;
        if (rise_tick) begin
            case (state_q)
                IDLE:    start_byte = 1'b1;
                SHIFT:   start_byte = (bit_cnt_q == '0);
                default: start_byte = 1'b1;
            endcase
            if (start_byte) begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = {rd_data[6:0], 1'b0};
                    din_d     = rd_data[7];
                    frame_d   = 1'b1;
                    bit_cnt_d = 3'd7;
                end else begin
`ifdef SSP_TX_IDLE_FILL_EN
                    shreg_d   = '0;
                    din_d     = 1'b0;
                    frame_d   = 1'b1;
                    bit_cnt_d = 3'd7;
`else
                    din_d     = 1'b0;
                    frame_d   = 1'b0;
`endif
                end
            end else begin
                frame_d   = 1'b0;
                din_d     = shreg_q[7];
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ssp_din   <= 1'b0;
            ssp_frame <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            ssp_din   <= din_d;
            ssp_frame <= frame_d;
        end
    end

endmodule

// File: tb/tb_ssp_tx_framer.sv
// Directed bench for ssp_tx_framer at CLK_DIV=4, FIFO_DEPTH=4; expectations are hand-derived edge by edge.
// Rise ticks fall on edges 4,8,12,... counted from the last reset release.
module tb_ssp_tx_framer;

    localparam int FD = 4;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ssp_clk;
    logic       ssp_frame;
    logic       ssp_din;

    int ecnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    ssp_tx_framer #(.FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (
        .ck_1356meg (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ssp_clk    (ssp_clk),
        .ssp_frame  (ssp_frame),
        .ssp_din    (ssp_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Park at the falling edge following posedge number k since release.
    task automatic at_edge(input int k);
        while (ecnt < k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] w;
        logic [7:0]  q [4];
        int          frames;
        int          din_hi;
        logic        prev_f;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // 1: reset and divider start
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_clk",      ssp_clk,    0);
        check("rst_frame",    ssp_frame,  0);
        check("rst_din",      ssp_din,    0);
        check("rst_level",    fifo_level, 0);
        check("rst_overflow", overflow,   0);
        check("rst_ready",    tx_ready,   0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", tx_ready, 1);
        at_edge(3);
        check("clk_before_first_rise", ssp_clk, 0);
        at_edge(4);
        check("first_rise", ssp_clk, 1);

        // 2: single byte 0xA5
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        at_edge(5);
        tx_valid = 1'b0;
        check("a5_level_after_push", fifo_level, 1);
        at_edge(7);
        check("a5_no_early_frame", ssp_frame, 0);
        at_edge(8);
        check("a5_frame_start", ssp_frame, 1);
        check("a5_bit7",        ssp_din,   1);
        check("a5_level_popped", fifo_level, 0);
        at_edge(10);
        check("a5_frame_held", ssp_frame, 1);
        b = 8'hA5;
        for (int k = 1; k < 8; k++) begin
            at_edge(8 + 4 * k);
            check($sformatf("a5_bit%0d", 7 - k), ssp_din, b[7 - k]);
            check($sformatf("a5_frame_low%0d", k), ssp_frame, 0);
        end
        at_edge(38);
        check("clk_fall", ssp_clk, 0);
        at_edge(40);
        check("a5_idle_din",   ssp_din,   0);
        check("a5_idle_frame", ssp_frame, 0);

        // 3: back-to-back 0x3C, 0xFF
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        at_edge(41);
        tx_data  = 8'hFF;
        at_edge(42);
        tx_valid = 1'b0;
        check("b2b_level", fifo_level, 2);
        at_edge(44);
        check("b2b_level_after_pop", fifo_level, 1);
        w = 16'h3CFF;
        for (int k = 0; k < 16; k++) begin
            at_edge(44 + 4 * k);
            check($sformatf("b2b_din%0d", k),   ssp_din,   w[15 - k]);
            check($sformatf("b2b_frame%0d", k), ssp_frame, (k == 0 || k == 8) ? 1 : 0);
        end
        at_edge(108);
        check("b2b_idle_din",   ssp_din,   0);
        check("b2b_idle_frame", ssp_frame, 0);

        // 4: overflow while a byte shifts
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        at_edge(109);
        tx_valid = 1'b0;
        at_edge(112);
        check("ovf_shift_start", ssp_frame, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        at_edge(113);
        tx_data  = 8'h22;
        at_edge(114);
        tx_data  = 8'h33;
        at_edge(115);
        check("ovf_level3", fifo_level, 3);
        check("ovf_ready3", tx_ready,   1);
        tx_data  = 8'h44;
        at_edge(116);
        check("ovf_level4",   fifo_level, 4);
        check("ovf_ready4",   tx_ready,   0);
        check("ovf_not_yet",  overflow,   0);
        tx_data  = 8'h55;
        at_edge(117);
        tx_valid = 1'b0;
        check("ovf_set",        overflow,   1);
        check("ovf_level_hold", fifo_level, 4);
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int j = 0; j < 4; j++) begin
            b = q[j];
            for (int k = 0; k < 8; k++) begin
                at_edge(144 + 32 * j + 4 * k);
                check($sformatf("q%0d_bit%0d", j, 7 - k), ssp_din, b[7 - k]);
                if (k == 0) begin
                    check($sformatf("q%0d_frame", j), ssp_frame, 1);
                    check($sformatf("q%0d_level", j), fifo_level, 3 - j);
                end
            end
        end
        at_edge(272);
        check("ovf_drop_idle_frame", ssp_frame, 0);
        check("ovf_drop_idle_din",   ssp_din,   0);
        check("ovf_sticky",          overflow,  1);

        // 5: reset mid-byte with two queued
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        at_edge(273);
        tx_valid = 1'b0;
        at_edge(276);
        check("r81_frame", ssp_frame, 1);
        check("r81_bit7",  ssp_din,   1);
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        at_edge(277);
        tx_data  = 8'h66;
        at_edge(278);
        tx_valid = 1'b0;
        check("r81_queued", fifo_level, 2);
        at_edge(292);
        check("r81_bit3",     ssp_din, 0);
        check("r81_clk_high", ssp_clk, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_clk",      ssp_clk,    0);
        check("mid_rst_frame",    ssp_frame,  0);
        check("mid_rst_din",      ssp_din,    0);
        check("mid_rst_level",    fifo_level, 0);
        check("mid_rst_overflow", overflow,   0);
        check("mid_rst_ready",    tx_ready,   0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", tx_ready, 1);
`ifndef SSP_TX_IDLE_FILL_EN
        frames = 0;
        for (int k = 1; k <= 40; k++) begin
            at_edge(k);
            if (ssp_frame) frames++;
        end
        check("no_resume_frames", frames, 0);
`endif

        // 6: long idle
        at_edge(40);
        prev_f = ssp_frame;
        frames = 0;
        din_hi = 0;
        for (int k = 41; k <= 168; k++) begin
            at_edge(k);
            if (ssp_frame && !prev_f) frames++;
            if (ssp_din) din_hi++;
            prev_f = ssp_frame;
        end
`ifdef SSP_TX_IDLE_FILL_EN
        check("idle_fill_frames", frames, 4);
`else
        check("idle_frames", frames, 0);
`endif
        check("idle_din",   din_hi,     0);
        check("idle_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
